// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing for the sequential shift-add multiplier control.
package mul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH) + 1;
endpackage

// File: rtl/mul_adder.sv
// mul_adder: WIDTH+WIDTH -> WIDTH+1 partial-sum adder; i_a can be forced to zero, i_b gated by i_b_en.
module mul_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_a_zero,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_en,
  output logic [WIDTH:0]   o_sum
);
  logic [WIDTH-1:0] w_a, w_b;
  assign w_a   = i_a_zero ? '0 : i_a;
  assign w_b   = i_b_en ? i_b : '0;
  assign o_sum = {1'b0, w_a} + {1'b0, w_b};
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: Moore control + adder stage driving an external shift-add product register.
// Optional sticky start-while-busy flag enabled by MUL_START_ERR_EN.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               prod_lsb,
  input  logic [WIDTH-1:0]   prod_hi,
  output logic [2*WIDTH-1:0] product_in,
  output logic               wrctrl,
  output logic               strctrl,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               start_err
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   w_sum;
  logic             w_last;

  assign w_last = r_cnt == CNT_W'(WIDTH - 1);

  // The register keeps a stale upper half after load, so the first pass ignores prod_hi.
  mul_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a      (prod_hi),
    .i_a_zero (r_cnt == '0),
    .i_b      (r_mcand),
    .i_b_en   (prod_lsb),
    .o_sum    (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_mcand <= multiplicand_in;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = ADD;
      ADD:     w_next = SHIFT;
      SHIFT:   w_next = w_last ? DONE : ADD;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    wrctrl     = r_state == LOAD;
    strctrl    = r_state == ADD;
    ready      = r_state == IDLE || r_state == DONE;
    busy       = r_state == LOAD || r_state == ADD || r_state == SHIFT;
    done       = r_state == DONE;
    product_in = wrctrl ? {{WIDTH{1'b0}}, multiplier_in} :
                 strctrl ? {w_sum, {(WIDTH-1){1'b0}}} : '0;
  end

`ifdef MUL_START_ERR_EN
  logic r_start_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_start_err <= 1'b0;
    else if (start && r_state != IDLE) r_start_err <= 1'b1;
  end
  assign start_err = r_start_err;
`else
  assign start_err = 1'b0;
`endif
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed test of mul_sequencer paired with a behavioural product register.
module tb_mul_sequencer;
  logic        clk = 0, reset = 1, start = 0;
  logic [31:0] mc = 0, mp = 0, prod_hi;
  logic        prod_lsb;
  logic [63:0] product_in, r_prod;
  logic        wrctrl, strctrl, ready, busy, done, start_err;
  int          errors = 0, checks = 0;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand_in(mc), .multiplier_in(mp),
    .prod_lsb(prod_lsb), .prod_hi(prod_hi),
    .product_in(product_in), .wrctrl(wrctrl), .strctrl(strctrl),
    .ready(ready), .busy(busy), .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  // Product register: load takes the low half only; a sum write lands on [63:31] while the low half shifts right.
  always_ff @(posedge clk) begin
    if (wrctrl) r_prod[31:0] <= product_in[31:0];
    else if (strctrl) r_prod <= {product_in[63:31], r_prod[31:1]};
  end
  assign prod_lsb = r_prod[0];
  assign prod_hi  = r_prod[63:32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                         output int lat, output int n_wr, output int n_str);
    @(negedge clk);
    mc = a; mp = b; start = 1;
    n_wr = 0; n_str = 0; lat = 0;
    @(negedge clk);
    start = 0;
    while (!done && lat < 200) begin
      n_wr += int'(wrctrl);
      n_str += int'(strctrl);
      if (lat == pulse_at) begin
        start = 1; mc = 32'd99; mp = 32'd99;
      end else start = 0;
      @(negedge clk);
      lat++;
    end
    start = 0;
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int pulse_at);
    int lat, n_wr, n_str;
    run_mul(a, b, pulse_at, lat, n_wr, n_str);
    check({tag, " latency"}, 64'(lat), 64'd65);
    check({tag, " product"}, r_prod, exp);
    check({tag, " ready"}, 64'(ready), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " wr pulses"}, 64'(n_wr), 64'd1);
    check({tag, " str pulses"}, 64'(n_str), 64'd32);
    @(negedge clk);
    check({tag, " done one-shot"}, 64'(done), 64'd0);
    check({tag, " frozen"}, r_prod, exp);
  endtask

  initial begin
    logic exp_err;
    #12;
    check("rst ready", 64'(ready), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst wrctrl", 64'(wrctrl), 64'd0);
    check("rst strctrl", 64'(strctrl), 64'd0);
    check("rst start_err", 64'(start_err), 64'd0);
    @(negedge clk);
    reset = 0;
    do_mul("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, -1);
    do_mul("maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    do_mul("7x9", 32'd7, 32'd9, 64'h0000_0000_0000_003F, -1);
    do_mul("0xk", 32'd0, 32'h1234_5678, 64'h0, -1);
    do_mul("kx1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, -1);
    check("no err yet", 64'(start_err), 64'd0);
    do_mul("6x7 start pulse", 32'd6, 32'd7, 64'h0000_0000_0000_002A, 10);
`ifdef MUL_START_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("start_err", 64'(start_err), 64'(exp_err));
    repeat (3) @(negedge clk);
    check("start_err held", 64'(start_err), 64'(exp_err));
    @(negedge clk);
    mc = 32'd5; mp = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    check("mid busy", 64'(busy), 64'd1);
    reset = 1;
    #1;
    check("mid rst ready", 64'(ready), 64'd1);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst done", 64'(done), 64'd0);
    check("mid rst start_err", 64'(start_err), 64'd0);
    @(negedge clk);
    reset = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 70; i++) begin
        @(negedge clk);
        seen += int'(done) + int'(busy);
      end
      check("no done after rst", 64'(seen), 64'd0);
    end
    do_mul("2x2", 32'd2, 32'd2, 64'h0000_0000_0000_0004, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
